fetch_unit: RTL and testbench

- Instruction fetch stage. Produces the instruction word and the opcode/funct fields consumed by the decode-stage control unit.
- Keeps the PC and issues valid/ready requests to instruction memory.
- Buffers returned words in a small FIFO and presents them to decode with a stall/redirect interface.
- Sits between instruction memory and the IF/ID boundary; branch resolution feeds back a redirect.

---
 rtl/fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, instruction buffer FIFO,
// stall/redirect interface toward decode.
// Optional macro FETCH_BYPASS_EN: when the buffer is empty, an accepted response drives the
// decode outputs in the same cycle instead of one cycle later.
// A response arriving with no request outstanding is dropped without any other effect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0040_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     req_pc_q, req_pc_d;
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic [31:0]     mem_instr [FIFO_DEPTH];
   logic [31:0]     mem_pc    [FIFO_DEPTH];

   logic            outstanding;
   logic            credit;
   logic            fifo_empty;
   logic            resp_take;
   logic            push;
   logic            pop;
   logic            req_fire;
   logic [31:0]     redirect_tgt;
   logic            out_valid;
   logic [31:0]     out_instr;
   logic [31:0]     out_pc;
`ifdef FETCH_BYPASS_EN
   logic            bypass;
`endif

   // Buffer control: which responses are kept, what leaves, and the next occupancy
   always_comb begin
      redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
      outstanding  = (state_q == StWait) || (state_q == StDrop);
      fifo_empty   = (count_q == '0);
      credit       = (32'(count_q) + 32'(outstanding)) < FIFO_DEPTH;
      // Only a response to a live request in WAIT is kept; the redirect cycle discards it
      resp_take    = (state_q == StWait) && imem_resp_valid && !redirect;
      pop          = !fifo_empty && !stall && !redirect;
`ifdef FETCH_BYPASS_EN
      bypass       = resp_take && fifo_empty;
      // A bypassed word consumed by decode this cycle never enters the buffer
      push         = resp_take && !(bypass && !stall);
`else
      push         = resp_take;
`endif
      if (redirect) begin
         count_d = '0;
      end else begin
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   // Request FSM next-state, PC update and request outputs
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      req_pc_d       = req_pc_q;
      imem_req_valid = 1'b0;
      imem_req_addr  = pc_q;
      req_fire       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (redirect) begin
               pc_d    = redirect_tgt;
               state_d = StReq;
            end else if (credit) begin
               state_d = StReq;
            end
         end
         StReq: begin
            imem_req_valid = 1'b1;
            req_fire       = imem_req_ready;
            if (redirect) begin
               // Unaccepted request is simply retargeted; an accepted one must be drained
               pc_d    = redirect_tgt;
               state_d = req_fire ? StDrop : StReq;
            end else if (req_fire) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + 32'd4;
               state_d  = StWait;
            end
         end
         StWait: begin
            if (redirect) begin
               pc_d    = redirect_tgt;
               // If the response lands in the redirect cycle nothing is left to drop
               state_d = imem_resp_valid ? StReq : StDrop;
            end else if (imem_resp_valid) begin
               state_d = (32'(count_d) < FIFO_DEPTH) ? StReq : StIdle;
            end
         end
         StDrop: begin
            if (redirect) begin
               pc_d = redirect_tgt;
            end
            if (imem_resp_valid) begin
               state_d = StReq;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM, PC and buffer pointer registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         count_q  <= count_d;
         if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) begin
               wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
         end
      end
   end

   // Buffer storage; contents are don't-care while empty so no reset is needed
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr_q] <= imem_resp_data;
         mem_pc[wr_ptr_q]    <= req_pc_q;
      end
   end

   // Decode-side outputs, forced to zero while nothing valid is presented
   always_comb begin
      out_valid = !fifo_empty;
      out_instr = mem_instr[rd_ptr_q];
      out_pc    = mem_pc[rd_ptr_q];
`ifdef FETCH_BYPASS_EN
      if (bypass) begin
         out_valid = 1'b1;
         out_instr = imem_resp_data;
         out_pc    = req_pc_q;
      end
`endif
      instr_valid = out_valid;
      instr       = out_valid ? out_instr : '0;
      opcode      = out_valid ? out_instr[31:26] : '0;
      funct       = out_valid ? out_instr[5:0] : '0;
      pc_out      = out_valid ? out_pc : '0;
      pc_plus4    = out_valid ? (out_pc + 32'd4) : '0;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers handshakes, the stimulus process
// queues the expected decode-side words, and a monitor pops/compares each consumed output.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;
`ifdef FETCH_BYPASS_EN
   localparam logic LAT_AT = 1'b1;
   localparam logic LAT_AFTER = 1'b0;
`else
   localparam logic LAT_AT = 1'b0;
   localparam logic LAT_AFTER = 1'b1;
`endif

   logic        clk;
   logic        reset_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;

   fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .opcode         (opcode),
      .funct          (funct),
      .pc_out         (pc_out),
      .pc_plus4       (pc_plus4)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] pc4;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] fetched[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_pops = 0;
   int          fetch_count = 0;
   int          lat = 1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0040_0000: return 32'h2008_4005;
         32'h0040_0004: return 32'h0000_0020;
         default:       return {a[15:0], ~a[15:0]};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] w, input logic [5:0] op,
                           input logic [5:0] fn, input logic [31:0] pc4);
      exp_t e;
      e.pc = pc; e.word = w; e.op = op; e.fn = fn; e.pc4 = pc4;
      exp_q.push_back(e);
   endtask

   task automatic push_pc(input logic [31:0] pc);
      logic [31:0] w;
      w = mem_word(pc);
      push_exp(pc, w, w[31:26], w[5:0], pc + 32'd4);
   endtask

   task automatic wait_pops(input int target, input string name);
      int i;
      i = 0;
      while (n_pops < target && i < 300) begin
         @(negedge clk);
         i++;
      end
      check(name, 32'(n_pops >= target), 32'd1);
   endtask

   task automatic wait_hs(input string name);
      int i;
      i = 0;
      @(negedge clk);
      while (!(imem_req_valid && imem_req_ready) && i < 50) begin
         @(negedge clk);
         i++;
      end
      check(name, 32'(imem_req_valid && imem_req_ready), 32'd1);
   endtask

   task automatic wait_resp(input string name);
      int i;
      i = 0;
      @(negedge clk);
      while (!imem_resp_valid && i < 50) begin
         @(negedge clk);
         i++;
      end
      check(name, 32'(imem_resp_valid), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
      check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
      check({tag, "_instr"}, instr, 32'd0);
      check({tag, "_opcode"}, 32'(opcode), 32'd0);
      check({tag, "_funct"}, 32'(funct), 32'd0);
      check({tag, "_pc_out"}, pc_out, 32'd0);
      check({tag, "_pc_plus4"}, pc_plus4, 32'd0);
   endtask

   // Memory model: answers each handshake after lat cycles; survives DUT reset
   initial begin : mem_model
      logic        f;
      logic        pend;
      int          cd;
      logic [31:0] a;
      logic [31:0] paddr;
      pend = 1'b0; cd = 0; paddr = '0;
      imem_resp_valid = 1'b0;
      imem_resp_data = '0;
      forever begin
         @(negedge clk);
         f = imem_req_valid && imem_req_ready;
         a = imem_req_addr;
         @(posedge clk);
         #1;
         imem_resp_valid = 1'b0;
         if (f) begin
            pend = 1'b1; cd = lat; paddr = a;
            fetched.push_back(a);
            fetch_count++;
         end
         if (pend) begin
            cd--;
            if (cd <= 0) begin
               imem_resp_valid = 1'b1;
               imem_resp_data = mem_word(paddr);
               pend = 1'b0;
            end
         end
      end
   end

   // Monitor: every word consumed by decode is compared against the queue head
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && instr_valid && !stall && !redirect) begin
         n_pops++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got pc %h instr %h, want none", pc_out, instr);
         end else begin
            e = exp_q.pop_front();
            check("instr", instr, e.word);
            check("pc_out", pc_out, e.pc);
            check("pc_plus4", pc_plus4, e.pc4);
            check("opcode", 32'(opcode), 32'(e.op));
            check("funct", 32'(funct), 32'(e.fn));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      int base;
      int fc0;
      int hits;
      reset_n = 1'b1; imem_req_ready = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("rst");
      repeat (2) @(posedge clk);

      // Two-word program, memory always ready, 1-cycle responses
      push_exp(32'h0040_0000, 32'h2008_4005, 6'h08, 6'h05, 32'h0040_0004);
      push_exp(32'h0040_0004, 32'h0000_0020, 6'h00, 6'h20, 32'h0040_0008);
      push_pc(32'h0040_0008);
      push_pc(32'h0040_000C);
      @(negedge clk);
      imem_req_ready = 1'b1;
      reset_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wait_resp("p1_resp_seen");
         check("p1_valid_at_resp", 32'(instr_valid), 32'(LAT_AT));
         @(negedge clk);
         check("p1_valid_after_resp", 32'(instr_valid), 32'(LAT_AFTER));
      end
      @(posedge clk);
      #1 imem_req_ready = 1'b0;
      repeat (2) @(posedge clk);

      // Memory not ready: request held at next PC, then retargeted by redirect
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("p2_req_valid_held", 32'(imem_req_valid), 32'd1);
         check("p2_req_addr_held", imem_req_addr, 32'h0040_000C);
      end
      @(posedge clk);
      #1 redirect = 1'b1; redirect_pc = 32'h0040_0200;
      exp_q.delete();
      fc0 = fetch_count;
      @(posedge clk);
      #1 redirect = 1'b0;
      @(negedge clk);
      check("p2_retarget_addr", imem_req_addr, 32'h0040_0200);
      check("p2_retarget_valid", 32'(imem_req_valid), 32'd1);
      check("p2_flushed", 32'(instr_valid), 32'd0);
      check("p2_no_handshake", 32'(fetch_count - fc0), 32'd0);

      // Stall: buffer fills to depth, requests stop, head stable
      @(posedge clk);
      #1 stall = 1'b1; imem_req_ready = 1'b1;
      fc0 = fetch_count;
      repeat (10) @(negedge clk);
      check("stall_req_count", 32'(fetch_count - fc0), 32'd2);
      check("stall_req_stopped", 32'(imem_req_valid), 32'd0);
      check("stall_head_valid", 32'(instr_valid), 32'd1);
      check("stall_head_pc", pc_out, 32'h0040_0200);
      check("stall_head_instr", instr, mem_word(32'h0040_0200));
      hits = 0;
      foreach (fetched[j]) if (fetched[j] == 32'h0040_000C) hits++;
      check("old_addr_never_fetched", 32'(hits), 32'd0);
      for (int k = 0; k < 8; k++) push_pc(32'h0040_0200 + 32'(4 * k));
      base = n_pops;
      @(posedge clk);
      #1 stall = 1'b0;
      wait_pops(base + 4, "stall_release_drain");

      // Redirect while a request is in flight: its response is dropped
      lat = 3;
      wait_hs("p3_hs");
      @(posedge clk);
      #1 redirect = 1'b1; redirect_pc = 32'h0040_0103;
      exp_q.delete();
      for (int k = 0; k < 4; k++) push_pc(32'h0040_0100 + 32'(4 * k));
      base = n_pops;
      @(posedge clk);
      #1 redirect = 1'b0;
      @(negedge clk);
      check("p3_flushed", 32'(instr_valid), 32'd0);
      check("p3_drop_no_req", 32'(imem_req_valid), 32'd0);
      wait_hs("p3_hs_after");
      check("p3_new_addr", imem_req_addr, 32'h0040_0100);
      wait_pops(base + 2, "p3_drain");

      // Reset in the middle of a wait; the late response must be ignored
      wait_hs("p4_hs");
      @(posedge clk);
      #1 imem_req_ready = 1'b0; reset_n = 1'b0;
      exp_q.delete();
      #1 check_reset_outputs("midrst");
      @(negedge clk);
      reset_n = 1'b1;
      lat = 1;
      repeat (4) @(negedge clk);
      check("p4_late_ignored", 32'(instr_valid), 32'd0);
      check("p4_restart_valid", 32'(imem_req_valid), 32'd1);
      check("p4_restart_addr", imem_req_addr, RESET_PC);
      push_exp(32'h0040_0000, 32'h2008_4005, 6'h08, 6'h05, 32'h0040_0004);
      push_exp(32'h0040_0004, 32'h0000_0020, 6'h00, 6'h20, 32'h0040_0008);
      push_pc(32'h0040_0008);
      push_pc(32'h0040_000C);
      base = n_pops;
      @(posedge clk);
      #1 imem_req_ready = 1'b1;
      wait_pops(base + 2, "p4_drain");
      @(posedge clk);
      #1 stall = 1'b1; imem_req_ready = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
